// File: rtl/jump_target_pkg.sv
// ============================================================================
//  Module      : jump_target_pkg
//  Description : Shared operation encoding and alignment constant for the
//                decode-stage jump target unit and its return-address stack.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jump_target_pkg;

    // Operation kinds presented on the 3-bit op port. Codes 6 and 7 are
    // unused and behave like OP_NONE.
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_J    = 3'd1,
        OP_JAL  = 3'd2,
        OP_BR   = 3'd3,
        OP_JR   = 3'd4,
        OP_JALR = 3'd5
    } op_e;

    // Low two bits of every word-aligned instruction address.
    localparam logic [1:0] c_align = 2'b00;

endpackage : jump_target_pkg

`default_nettype wire

// File: rtl/return_address_stack.sv
// ============================================================================
//  Module      : return_address_stack
//  Description : Circular return-address stack. The top entry is read and
//                checked against the actual rs value from pre-update state;
//                a pop followed by a push in the same cycle replaces the top.
//                When full, a push overwrites the oldest entry and flags it.
//  Revision    : 1.0 - initial release
//
//  Parameters  : ADDR_WIDTH - entry width
//                RAS_DEPTH  - number of entries (power of two, >= 2)
//  Ports       : clock, reset_n   - clock, async active-low reset
//                push, pop        - update requests (already qualified)
//                push_data        - return address to push
//                check_data       - actual jump-register target
//                predicted        - top entry on a non-empty pop, else 0
//                hit_valid        - pop found an entry
//                mispredict       - pop on empty or top != check_data
//                overflow         - push overwrote the oldest entry
// ============================================================================
`default_nettype none

module return_address_stack
    import jump_target_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    input  logic [ADDR_WIDTH-1:0] check_data,
    output logic [ADDR_WIDTH-1:0] predicted,
    output logic                  hit_valid,
    output logic                  mispredict,
    output logic                  overflow
);

    localparam int c_ptr_w = $clog2(RAS_DEPTH);
    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] r_entries [RAS_DEPTH];
    logic [c_ptr_w-1:0]    r_top_ptr;
    logic [c_cnt_w-1:0]    r_count;

    logic                  w_empty;
    logic                  w_pop_eff;
    logic [c_ptr_w-1:0]    w_ptr_after_pop;
    logic [c_cnt_w-1:0]    w_cnt_after_pop;
    logic [c_ptr_w-1:0]    w_wr_ptr;
    logic [c_ptr_w-1:0]    w_ptr_next;
    logic [c_cnt_w-1:0]    w_cnt_next;
    logic [ADDR_WIDTH-1:0] w_top;

    assign w_empty   = (r_count == '0);
    assign w_pop_eff = pop && !w_empty;
    assign w_top     = r_entries[r_top_ptr];

    // The pop is applied first so that a JALR return (pop + push) lands its
    // write on the slot just vacated, i.e. it replaces the top entry.
    assign w_ptr_after_pop = w_pop_eff ? (r_top_ptr - c_ptr_w'(1)) : r_top_ptr;
    assign w_cnt_after_pop = w_pop_eff ? (r_count - c_cnt_w'(1))   : r_count;
    assign w_wr_ptr        = w_ptr_after_pop + c_ptr_w'(1);

    assign overflow   = push && (w_cnt_after_pop == c_full);
    assign w_ptr_next = push ? w_wr_ptr : w_ptr_after_pop;
    assign w_cnt_next = (push && !overflow) ? (w_cnt_after_pop + c_cnt_w'(1))
                                            : w_cnt_after_pop;

    assign predicted  = w_pop_eff ? w_top : '0;
    assign hit_valid  = w_pop_eff;
    assign mispredict = pop && (w_empty || (w_top != check_data));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_top_ptr <= '0;
            r_count   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            r_top_ptr <= w_ptr_next;
            r_count   <= w_cnt_next;
            if (push) begin
                r_entries[w_wr_ptr] <= push_data;
            end
        end
    end

endmodule : return_address_stack

`default_nettype wire

// File: rtl/jump_target_unit.sv
// ============================================================================
//  Module      : jump_target_unit
//  Description : Decode-stage jump/branch target calculator with optional
//                return-address stack prediction for `jr $ra`. Results are
//                registered (1-cycle latency) and honour stall and flush;
//                flush takes priority over stall.
//  Revision    : 1.0 - initial release
//
//  Build macro : JUMP_TARGET_RAS_EN - compile in the return-address stack.
//                Without it, RAS outputs are 0 and every return pop reports
//                a mispredict so fetch waits for rs.
//
//  Parameters  : ADDR_WIDTH (>= 28), RAS_DEPTH (power of two, >= 2)
//  Ports       : clock, reset_n           - clock, async active-low reset
//                stall, flush             - pipeline control
//                in_valid, op             - request and operation kind
//                raw_address, imm         - J index field, branch word offset
//                pc_plus_four, reg_target - next PC, rs value
//                is_return                - JR/JALR through $ra
//                out_valid, target        - registered result
//                link_address, misaligned - return address, target[1:0]!=0
//                ras_predicted, ras_valid,
//                ras_mispredict,
//                ras_overflow             - return prediction status
// ============================================================================
`default_nettype none

module jump_target_unit
    import jump_target_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [2:0]            op,
    input  logic [25:0]           raw_address,
    input  logic [15:0]           imm,
    input  logic [ADDR_WIDTH-1:0] pc_plus_four,
    input  logic [ADDR_WIDTH-1:0] reg_target,
    input  logic                  is_return,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] link_address,
    output logic                  misaligned,
    output logic [ADDR_WIDTH-1:0] ras_predicted,
    output logic                  ras_valid,
    output logic                  ras_mispredict,
    output logic                  ras_overflow
);

    op_e                   w_op;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_jump_target;
    logic [ADDR_WIDTH-1:0] w_br_offset;
    logic [ADDR_WIDTH-1:0] w_br_target;
    logic [ADDR_WIDTH-1:0] w_link;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_link_out;
    logic                  w_misaligned;
    logic                  w_is_reg;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_ras_predicted;
    logic                  w_ras_valid;
    logic                  w_ras_mispredict;
    logic                  w_ras_overflow;

    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] r_link_address;
    logic                  r_misaligned;
    logic [ADDR_WIDTH-1:0] r_ras_predicted;
    logic                  r_ras_valid;
    logic                  r_ras_mispredict;
    logic                  r_ras_overflow;

    assign w_op     = op_e'(op);
    assign w_accept = in_valid && !stall && !flush;

    // Pseudo-direct target keeps the PC region bits above bit 27; at the
    // minimum width of 28 there is no region and the index fills the address.
    if (ADDR_WIDTH > 28) begin : g_region
        assign w_jump_target = {pc_plus_four[ADDR_WIDTH-1:28], raw_address, c_align};
    end else begin : g_no_region
        assign w_jump_target = {raw_address, c_align};
    end

    // Sign-extended word offset shifted into a byte offset; the sum wraps.
    assign w_br_offset = {{(ADDR_WIDTH-18){imm[15]}}, imm, c_align};
    assign w_br_target = pc_plus_four + w_br_offset;
    // Return address skips the delay slot.
    assign w_link      = pc_plus_four + ADDR_WIDTH'(4);

    always_comb begin
        w_target     = '0;
        w_link_out   = '0;
        w_misaligned = 1'b0;
        w_is_reg     = 1'b0;
        case (w_op)
            OP_J: begin
                w_target = w_jump_target;
            end
            OP_JAL: begin
                w_target   = w_jump_target;
                w_link_out = w_link;
            end
            OP_BR: begin
                w_target = w_br_target;
            end
            OP_JR: begin
                w_target     = reg_target;
                w_misaligned = (reg_target[1:0] != c_align);
                w_is_reg     = 1'b1;
            end
            OP_JALR: begin
                w_target     = reg_target;
                w_link_out   = w_link;
                w_misaligned = (reg_target[1:0] != c_align);
                w_is_reg     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_pop = w_accept && w_is_reg && is_return;

`ifdef JUMP_TARGET_RAS_EN
    logic w_push;

    // Every linking jump pushes; a JALR return pops first, then pushes.
    assign w_push = w_accept && ((w_op == OP_JAL) || (w_op == OP_JALR));

    return_address_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (w_push),
        .pop        (w_pop),
        .push_data  (w_link),
        .check_data (reg_target),
        .predicted  (w_ras_predicted),
        .hit_valid  (w_ras_valid),
        .mispredict (w_ras_mispredict),
        .overflow   (w_ras_overflow)
    );
`else
    // No prediction storage: every return must wait for the real rs value.
    assign w_ras_predicted  = '0;
    assign w_ras_valid      = 1'b0;
    assign w_ras_mispredict = w_pop;
    assign w_ras_overflow   = 1'b0;
`endif

    // Flush beats stall; results hold until the next accepted input, while
    // out_valid drops on any unaccepted, unstalled cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid      <= 1'b0;
            r_target         <= '0;
            r_link_address   <= '0;
            r_misaligned     <= 1'b0;
            r_ras_predicted  <= '0;
            r_ras_valid      <= 1'b0;
            r_ras_mispredict <= 1'b0;
            r_ras_overflow   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (!stall) begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_target         <= w_target;
                r_link_address   <= w_link_out;
                r_misaligned     <= w_misaligned;
                r_ras_predicted  <= w_ras_predicted;
                r_ras_valid      <= w_ras_valid;
                r_ras_mispredict <= w_ras_mispredict;
                r_ras_overflow   <= w_ras_overflow;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign target         = r_target;
    assign link_address   = r_link_address;
    assign misaligned     = r_misaligned;
    assign ras_predicted  = r_ras_predicted;
    assign ras_valid      = r_ras_valid;
    assign ras_mispredict = r_ras_mispredict;
    assign ras_overflow   = r_ras_overflow;

endmodule : jump_target_unit

`default_nettype wire

// File: tb/tb_jump_target_unit.sv
// ============================================================================
//  Module      : tb_jump_target_unit
//  Description : Directed bench for jump_target_unit. Expected results come
//                from a small reference model (queue-based return stack) and
//                are pushed to a scoreboard when stimulus is driven, then
//                popped and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jump_target_unit;

    localparam int AW    = 32;
    localparam int DEPTH = 8;
`ifdef JUMP_TARGET_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_J    = 3'd1;
    localparam logic [2:0] T_JAL  = 3'd2;
    localparam logic [2:0] T_BR   = 3'd3;
    localparam logic [2:0] T_JR   = 3'd4;
    localparam logic [2:0] T_JALR = 3'd5;

    typedef struct packed {
        logic          ov;
        logic [AW-1:0] tgt;
        logic [AW-1:0] link;
        logic          mis;
        logic [AW-1:0] pred;
        logic          rv;
        logic          mp;
        logic          ovf;
    } exp_t;

    logic          clock;
    logic          reset_n;
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [2:0]    op;
    logic [25:0]   raw_address;
    logic [15:0]   imm;
    logic [AW-1:0] pc_plus_four;
    logic [AW-1:0] reg_target;
    logic          is_return;
    logic          out_valid;
    logic [AW-1:0] target;
    logic [AW-1:0] link_address;
    logic          misaligned;
    logic [AW-1:0] ras_predicted;
    logic          ras_valid;
    logic          ras_mispredict;
    logic          ras_overflow;

    int            n_cmp = 0;
    int            n_err = 0;
    exp_t          sb_q[$];
    logic [AW-1:0] ras_q[$];
    exp_t          last;

    jump_target_unit #(
        .ADDR_WIDTH (AW),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .op             (op),
        .raw_address    (raw_address),
        .imm            (imm),
        .pc_plus_four   (pc_plus_four),
        .reg_target     (reg_target),
        .is_return      (is_return),
        .out_valid      (out_valid),
        .target         (target),
        .link_address   (link_address),
        .misaligned     (misaligned),
        .ras_predicted  (ras_predicted),
        .ras_valid      (ras_valid),
        .ras_mispredict (ras_mispredict),
        .ras_overflow   (ras_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_field(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_field({tag, ".out_valid"},      AW'(out_valid),      AW'(e.ov));
        check_field({tag, ".target"},         target,              e.tgt);
        check_field({tag, ".link_address"},   link_address,        e.link);
        check_field({tag, ".misaligned"},     AW'(misaligned),     AW'(e.mis));
        check_field({tag, ".ras_predicted"},  ras_predicted,       e.pred);
        check_field({tag, ".ras_valid"},      AW'(ras_valid),      AW'(e.rv));
        check_field({tag, ".ras_mispredict"}, AW'(ras_mispredict), AW'(e.mp));
        check_field({tag, ".ras_overflow"},   AW'(ras_overflow),   AW'(e.ovf));
    endtask

    task automatic drive(input logic [2:0] o, input logic [25:0] raw, input logic [15:0] im,
                         input logic [AW-1:0] pc, input logic [AW-1:0] rt, input logic ret,
                         input logic iv, input logic st, input logic fl);
        op           = o;
        raw_address  = raw;
        imm          = im;
        pc_plus_four = pc;
        reg_target   = rt;
        is_return    = ret;
        in_valid     = iv;
        stall        = st;
        flush        = fl;
    endtask

    // Reference model of one accepted operation; updates the model stack.
    task automatic model_op(input logic [2:0] o, input logic [25:0] raw, input logic [15:0] im,
                            input logic [AW-1:0] pc, input logic [AW-1:0] rt, input logic ret,
                            output exp_t e);
        logic [AW-1:0] lnk;
        logic [AW-1:0] top;
        e   = '0;
        e.ov = 1'b1;
        lnk = pc + 32'd4;
        case (o)
            T_J, T_JAL:   e.tgt = {pc[31:28], raw, 2'b00};
            T_BR:         e.tgt = pc + (32'($signed(im)) << 2);
            T_JR, T_JALR: begin
                e.tgt = rt;
                e.mis = (rt[1:0] != 2'b00);
            end
            default:      e.tgt = '0;
        endcase
        if (o == T_JAL || o == T_JALR) e.link = lnk;
        if ((o == T_JR || o == T_JALR) && ret) begin
            if (RAS_EN && ras_q.size() > 0) begin
                top    = ras_q.pop_back();
                e.pred = top;
                e.rv   = 1'b1;
                e.mp   = (top != rt);
            end else begin
                e.mp = 1'b1;
            end
        end
        if (RAS_EN && (o == T_JAL || o == T_JALR)) begin
            ras_q.push_back(lnk);
            if (ras_q.size() > DEPTH) begin
                ras_q.delete(0);
                e.ovf = 1'b1;
            end
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
            last = e;
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [25:0] raw,
                         input logic [15:0] im, input logic [AW-1:0] pc,
                         input logic [AW-1:0] rt, input logic ret);
        exp_t e;
        drive(o, raw, im, pc, rt, ret, 1'b1, 1'b0, 1'b0);
        model_op(o, raw, im, pc, rt, ret, e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        sb_check(tag);
    endtask

    initial begin
        exp_t e;
        last    = '0;
        reset_n = 1'b0;
        drive(T_NONE, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_outputs("reset", '0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Target arithmetic
        do_op("j_region",  T_J,  26'h0000040, 16'h0, 32'h4000_0010, '0, 1'b0);
        do_op("br_back",   T_BR, '0, 16'hFFFE, 32'h0000_0008, '0, 1'b0);
        do_op("br_wrap",   T_BR, '0, 16'h0001, 32'hFFFF_FFFC, '0, 1'b0);
        do_op("none",      T_NONE, 26'h3FFFFFF, 16'h1234, 32'h1111_1110, 32'h5, 1'b0);

        // Simple call/return, then return on empty stack
        do_op("jal_100",   T_JAL, 26'h0000080, 16'h0, 32'h0000_0100, '0, 1'b0);
        do_op("jr_ret_ok", T_JR,  '0, 16'h0, 32'h0000_0200, 32'h0000_0104, 1'b1);
        do_op("jr_empty",  T_JR,  '0, 16'h0, 32'h0000_0204, 32'h0000_0104, 1'b1);

        // Nine calls overflow an eight-deep stack; pops come back LIFO
        for (int i = 1; i <= 9; i++) begin
            do_op($sformatf("jal_ovf%0d", i), T_JAL, 26'(i), 16'h0, 32'h1000 + 32'(i) * 32'h10, '0, 1'b0);
        end
        for (int i = 9; i >= 2; i--) begin
            do_op($sformatf("pop_lifo%0d", i), T_JR, '0, 16'h0, 32'h2000,
                  32'h1004 + 32'(i) * 32'h10 + ((i == 6) ? 32'h8 : 32'h0), 1'b1);
        end
        do_op("pop_after_lifo", T_JR, '0, 16'h0, 32'h2000, 32'h1014, 1'b1);

        // JALR without return pushes; JALR return replaces the top entry
        do_op("jalr_push",  T_JALR, '0, 16'h0, 32'h0000_0200, 32'h0000_0800, 1'b0);
        do_op("jalr_swap",  T_JALR, '0, 16'h0, 32'h0000_0300, 32'h0000_0204, 1'b1);
        do_op("jr_swapped", T_JR,   '0, 16'h0, 32'h0000_0400, 32'h0000_0304, 1'b1);
        do_op("jr_empty2",  T_JR,   '0, 16'h0, 32'h0000_0400, 32'h0000_0304, 1'b1);

        // One entry on the stack, then misaligned JR, stall, flush
        do_op("jal_500",   T_JAL, '0, 16'h0, 32'h0000_0500, '0, 1'b0);
        do_op("jr_misal",  T_JR,  '0, 16'h0, 32'h0000_0600, 32'h0000_0102, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(T_JAL, 26'(i), 16'h0, 32'h0000_7000 + 32'(i) * 32'h10, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            @(posedge clock);
            #1;
            check_outputs($sformatf("stall%0d", i), last);
        end
        drive(T_JAL, '0, 16'h0, 32'h0000_7100, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        e    = last;
        e.ov = 1'b0;
        check_outputs("flush", e);
        last = e;
        drive(T_JAL, '0, 16'h0, 32'h0000_7200, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        check_outputs("stall_flush", last);
        do_op("jr_after_flush", T_JR, '0, 16'h0, 32'h0000_0700, 32'h0000_0504, 1'b1);
        drive(T_JAL, '0, 16'h0, 32'h0000_7300, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        e    = last;
        e.ov = 1'b0;
        check_outputs("idle", e);
        do_op("jr_empty3", T_JR, '0, 16'h0, 32'h0000_0700, 32'h0000_0504, 1'b1);

        // Reset mid-sequence discards the stack
        for (int i = 0; i < 3; i++) begin
            do_op($sformatf("jal_pre_rst%0d", i), T_JAL, '0, 16'h0, 32'h0000_0900 + 32'(i) * 32'h10, '0, 1'b0);
        end
        #1;
        reset_n = 1'b0;
        #1;
        check_outputs("mid_reset", '0);
        ras_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        do_op("jr_post_rst", T_JR, '0, 16'h0, 32'h0000_0A00, 32'h0000_0924, 1'b1);

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_jump_target_unit

`default_nettype wire
